// File: rtl/wb_pkg.sv
// Shared types for the register-file writeback port arbiter.
// Holds the entry layout stored in the per-requester FIFOs and the grant encoding.
package wb_pkg;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 4;
    localparam logic [ADDR_W-1:0] PC_ADDR = 4'd15;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic              pc;
    } wb_entry_t;

    typedef enum logic {
        GNT_A = 1'b0,
        GNT_B = 1'b1
    } grant_e;
endpackage

// File: rtl/wb_fifo.sv
// Small circular FIFO of writeback entries.
// Every slot is also exposed with its own valid bit so the top can build the busy mask.
module wb_fifo
    import wb_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  wb_entry_t             push_ent,
    input  logic                  pop,
    output wb_entry_t             head,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH-1:0]      ent_vld,
    output wb_entry_t [DEPTH-1:0] ents
);
    wb_entry_t [DEPTH-1:0] mem_q, mem_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push, do_pop;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign head    = mem_q[rd_ptr_q];
    assign ents    = mem_q;
    // Fullness is judged on the registered count, so a same-cycle pop never frees room.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_ent;
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        count_d = count_q + CW'(do_push) - CW'(do_pop);
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_vld
        logic [PW-1:0] off;
        assign off        = PW'(i) - rd_ptr_q;
        assign ent_vld[i] = (CW'(off) < count_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end
endmodule

// File: rtl/wb_port_arbiter.sv
// Shares the single register-file write port between scalar WB (A) and the vector unit (B).
// Round-robin between two small FIFOs, with PC updates from A always taking priority.
module wb_port_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4,
    parameter int DEPTH  = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 a_valid,
    input  logic [ADDR_W-1:0]    a_addr,
    input  logic [DATA_W-1:0]    a_data,
    input  logic                 a_pc,
    output logic                 a_ready,
    input  logic                 b_valid,
    input  logic [ADDR_W-1:0]    b_addr,
    input  logic [DATA_W-1:0]    b_data,
    output logic                 b_ready,
    output logic                 rf_we,
    output logic [ADDR_W-1:0]    rf_waddr,
    output logic [DATA_W-1:0]    rf_wdata,
    output logic                 pc_we,
    output logic [2**ADDR_W-1:0] busy_mask,
    output logic                 grant_b
);
    import wb_pkg::*;

    wb_entry_t             a_ent, b_ent, a_head, b_head, sel;
    wb_entry_t [DEPTH-1:0] a_ents, b_ents;
    logic [DEPTH-1:0]      a_vld, b_vld;
    logic                  a_full, a_empty, b_full, b_empty;
    logic                  gnt_a, gnt_b;
    grant_e                last_grant_q, last_grant_d;
    logic                  rdy_q, rdy_d;

    // Ready stays low through reset and comes up at the first edge after release.
    assign rdy_d   = 1'b1;
    assign a_ready = rdy_q && !a_full;
    assign b_ready = rdy_q && !b_full;

    always_comb begin
        a_ent = '{addr: a_addr, data: a_data, pc: a_pc};
        b_ent = '{addr: b_addr, data: b_data, pc: 1'b0};
    end

    wb_fifo #(.DEPTH(DEPTH)) u_fifo_a (
        .clk(clk), .rst_n(rst_n),
        .push(a_valid && a_ready), .push_ent(a_ent), .pop(gnt_a),
        .head(a_head), .full(a_full), .empty(a_empty),
        .ent_vld(a_vld), .ents(a_ents)
    );

    wb_fifo #(.DEPTH(DEPTH)) u_fifo_b (
        .clk(clk), .rst_n(rst_n),
        .push(b_valid && b_ready), .push_ent(b_ent), .pop(gnt_b),
        .head(b_head), .full(b_full), .empty(b_empty),
        .ent_vld(b_vld), .ents(b_ents)
    );

    always_comb begin
        gnt_a = !a_empty && (b_empty || a_head.pc || last_grant_q == GNT_B);
        gnt_b = !b_empty && !gnt_a;
        sel   = gnt_b ? b_head : a_head;
        rf_we = gnt_a || gnt_b;
        // Zero the fields when idle: an empty FIFO's head slot still holds stale data.
        rf_waddr = rf_we ? sel.addr : '0;
        rf_wdata = rf_we ? sel.data : '0;
        pc_we    = rf_we && sel.pc;
        grant_b  = gnt_b;
        last_grant_d = gnt_a ? GNT_A : (gnt_b ? GNT_B : last_grant_q);
    end

    always_comb begin
        busy_mask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (a_vld[i]) busy_mask[a_ents[i].addr] = 1'b1;
            if (b_vld[i]) busy_mask[b_ents[i].addr] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_q <= GNT_B;
            rdy_q        <= 1'b0;
        end else begin
            last_grant_q <= last_grant_d;
            rdy_q        <= rdy_d;
        end
    end
endmodule

// File: tb/tb_wb_port_arbiter.sv
// Scoreboarded bench for wb_port_arbiter: per-requester expected queues are
// filled when writes are accepted and drained by a monitor as rf writes appear.
module tb_wb_port_arbiter;
    import wb_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        a_valid = 1'b1;
    logic [3:0]  a_addr = 4'd7;
    logic [31:0] a_data = 32'h1;
    logic        a_pc = 1'b0;
    logic        a_ready;
    logic        b_valid = 1'b0;
    logic [3:0]  b_addr = '0;
    logic [31:0] b_data = '0;
    logic        b_ready;
    logic        rf_we;
    logic [3:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        pc_we;
    logic [15:0] busy_mask;
    logic        grant_b;

    typedef struct {
        logic [3:0]  addr;
        logic [31:0] data;
        logic        pc;
    } exp_t;

    exp_t sb_a[$];
    exp_t sb_b[$];
    int   n_checks = 0;
    int   n_fail = 0;

    wb_port_arbiter #(.DATA_W(32), .ADDR_W(4), .DEPTH(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data), .a_pc(a_pc), .a_ready(a_ready),
        .b_valid(b_valid), .b_addr(b_addr), .b_data(b_data), .b_ready(b_ready),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .pc_we(pc_we),
        .busy_mask(busy_mask), .grant_b(grant_b)
    );

    always #5 clk = ~clk;

    // Monitor: every rf write must match the oldest expected write of its requester.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && rf_we === 1'b1) begin
            n_checks++;
            if ((grant_b && sb_b.size() == 0) || (!grant_b && sb_a.size() == 0)) begin
                n_fail++;
                $display("FAIL sb_unexpected: write addr=%0d grant_b=%0b, expected no write", rf_waddr, grant_b);
            end else begin
                if (grant_b) e = sb_b.pop_front();
                else         e = sb_a.pop_front();
                if ({rf_waddr, rf_wdata, pc_we} !== {e.addr, e.data, e.pc}) begin
                    n_fail++;
                    $display("FAIL sb_write: got addr=%0d data=%h pc=%0b, expected addr=%0d data=%h pc=%0b",
                             rf_waddr, rf_wdata, pc_we, e.addr, e.data, e.pc);
                end
            end
        end
    end

    task automatic push_a(input logic [3:0] addr, input logic [31:0] data, input logic pc);
        a_valid = 1'b1; a_addr = addr; a_data = data; a_pc = pc;
        sb_a.push_back('{addr: addr, data: data, pc: pc});
    endtask

    task automatic push_b(input logic [3:0] addr, input logic [31:0] data);
        b_valid = 1'b1; b_addr = addr; b_data = data;
        sb_b.push_back('{addr: addr, data: data, pc: 1'b0});
    endtask

    task automatic idle();
        a_valid = 1'b0; b_valid = 1'b0; a_pc = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        n_checks++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL rst_rf_we: got %b, expected 0", rf_we); end
        n_checks++; if (busy_mask !== 16'h0) begin n_fail++; $display("FAIL rst_busy: got %h, expected 0", busy_mask); end
        n_checks++; if (a_ready !== 1'b0) begin n_fail++; $display("FAIL rst_a_ready: got %b, expected 0", a_ready); end
        n_checks++; if (b_ready !== 1'b0) begin n_fail++; $display("FAIL rst_b_ready: got %b, expected 0", b_ready); end
        #2 rst_n = 1'b1;
        #1;
        n_checks++; if (a_ready !== 1'b0) begin n_fail++; $display("FAIL ready_pre_edge: got %b, expected 0", a_ready); end
        @(negedge clk);
        n_checks++; if ({a_ready, b_ready} !== 2'b11) begin n_fail++; $display("FAIL ready_post_edge: got %b, expected 11", {a_ready, b_ready}); end
        n_checks++; if (busy_mask !== 16'h0) begin n_fail++; $display("FAIL rst_no_push: got %h, expected 0", busy_mask); end
        idle();
    endtask

    task automatic test_single();
        @(negedge clk);
        push_a(4'd3, 32'hDEADBEEF, 1'b0);
        @(negedge clk);
        idle();
        n_checks++; if ({rf_we, rf_waddr, grant_b} !== {1'b1, 4'd3, 1'b0}) begin n_fail++; $display("FAIL single_write: got we=%b addr=%0d gb=%b, expected we=1 addr=3 gb=0", rf_we, rf_waddr, grant_b); end
        n_checks++; if (busy_mask !== 16'h0008) begin n_fail++; $display("FAIL single_busy: got %h, expected 0008", busy_mask); end
        @(negedge clk);
        n_checks++; if (busy_mask !== 16'h0) begin n_fail++; $display("FAIL single_busy_clear: got %h, expected 0", busy_mask); end
        n_checks++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL single_idle: got %b, expected 0", rf_we); end
    endtask

    task automatic test_contention();
        logic [3:0] exp_addr [4];
        logic       exp_gb [4];
        exp_addr = '{4'd1, 4'd5, 4'd2, 4'd6};
        exp_gb   = '{1'b0, 1'b1, 1'b0, 1'b1};
        // A lone B write leaves B as the last grantee, so A should lead.
        @(negedge clk); push_b(4'd9, 32'h9999_0009);
        @(negedge clk); idle();
        @(negedge clk);
        push_a(4'd1, 32'h1111_0001, 1'b0);
        push_b(4'd5, 32'h5555_0005);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            n_checks++;
            if ({rf_we, rf_waddr, grant_b} !== {1'b1, exp_addr[k], exp_gb[k]}) begin
                n_fail++;
                $display("FAIL contention_%0d: got we=%b addr=%0d gb=%b, expected we=1 addr=%0d gb=%b",
                         k, rf_we, rf_waddr, grant_b, exp_addr[k], exp_gb[k]);
            end
            if (k == 0) begin
                push_a(4'd2, 32'h2222_0002, 1'b0);
                push_b(4'd6, 32'h6666_0006);
            end else idle();
        end
        @(negedge clk);
        n_checks++; if (sb_a.size() + sb_b.size() != 0) begin n_fail++; $display("FAIL contention_drain: got %0d pending, expected 0", sb_a.size() + sb_b.size()); end
    endtask

    task automatic test_pc_priority();
        // A lone A write makes A the last grantee; the PC update must still win.
        @(negedge clk); push_a(4'd8, 32'h8888_0008, 1'b0);
        @(negedge clk); idle();
        @(negedge clk);
        push_a(PC_ADDR, 32'h0000_F000, 1'b1);
        push_b(4'd4, 32'h4444_0004);
        @(negedge clk);
        idle();
        n_checks++; if ({rf_we, rf_waddr, pc_we, grant_b} !== {1'b1, 4'd15, 1'b1, 1'b0}) begin n_fail++; $display("FAIL pc_first: got we=%b addr=%0d pc=%b gb=%b, expected 1 15 1 0", rf_we, rf_waddr, pc_we, grant_b); end
        @(negedge clk);
        n_checks++; if ({rf_we, rf_waddr, pc_we, grant_b} !== {1'b1, 4'd4, 1'b0, 1'b1}) begin n_fail++; $display("FAIL pc_then_b: got we=%b addr=%0d pc=%b gb=%b, expected 1 4 0 1", rf_we, rf_waddr, pc_we, grant_b); end
        @(negedge clk);
        n_checks++; if (sb_a.size() + sb_b.size() != 0) begin n_fail++; $display("FAIL pc_drain: got %0d pending, expected 0", sb_a.size() + sb_b.size()); end
    endtask

    task automatic test_backpressure();
        logic [0:5] ardy_t, brdy_t;
        logic [0:7] we_t, gb_t;
        int na, nb;
        ardy_t = 6'b111010;
        brdy_t = 6'b110101;
        we_t   = 8'b01111111;
        gb_t   = 8'b00101010;
        na = 0; nb = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (c < 6) begin
                n_checks++; if (a_ready !== ardy_t[c]) begin n_fail++; $display("FAIL bp_a_ready_c%0d: got %b, expected %b", c, a_ready, ardy_t[c]); end
                n_checks++; if (b_ready !== brdy_t[c]) begin n_fail++; $display("FAIL bp_b_ready_c%0d: got %b, expected %b", c, b_ready, brdy_t[c]); end
            end
            n_checks++; if (rf_we !== we_t[c]) begin n_fail++; $display("FAIL bp_we_c%0d: got %b, expected %b", c, rf_we, we_t[c]); end
            if (we_t[c]) begin
                n_checks++; if (grant_b !== gb_t[c]) begin n_fail++; $display("FAIL bp_gb_c%0d: got %b, expected %b", c, grant_b, gb_t[c]); end
            end
            if (c == 3) begin
                n_checks++; if (busy_mask !== 16'h0206) begin n_fail++; $display("FAIL bp_busy: got %h, expected 0206", busy_mask); end
            end
            if (na < 4) begin
                a_valid = 1'b1; a_addr = 4'(na); a_data = 32'hA000_0000 + na; a_pc = 1'b0;
                if (ardy_t[c]) begin sb_a.push_back('{addr: 4'(na), data: 32'hA000_0000 + na, pc: 1'b0}); na++; end
            end else a_valid = 1'b0;
            if (nb < 3) begin
                b_valid = 1'b1; b_addr = 4'(8 + nb); b_data = 32'hB000_0000 + nb;
                if (brdy_t[c]) begin sb_b.push_back('{addr: 4'(8 + nb), data: 32'hB000_0000 + nb, pc: 1'b0}); nb++; end
            end else b_valid = 1'b0;
        end
        @(negedge clk);
        n_checks++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL bp_idle: got %b, expected 0", rf_we); end
        n_checks++; if (sb_a.size() + sb_b.size() != 0) begin n_fail++; $display("FAIL bp_drain: got %0d pending, expected 0", sb_a.size() + sb_b.size()); end
    endtask

    task automatic test_mid_reset();
        @(negedge clk);
        push_a(4'd10, 32'hC000_000A, 1'b0);
        push_b(4'd12, 32'hC000_000C);
        @(negedge clk);
        push_a(4'd11, 32'hC000_000B, 1'b0);
        push_b(4'd13, 32'hC000_000D);
        @(negedge clk);
        idle();
        n_checks++; if (busy_mask !== 16'h2C00) begin n_fail++; $display("FAIL mr_busy_loaded: got %h, expected 2C00", busy_mask); end
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if ({rf_we, pc_we, grant_b} !== 3'b000) begin n_fail++; $display("FAIL mr_outputs: got we/pc/gb=%b, expected 000", {rf_we, pc_we, grant_b}); end
        n_checks++; if (busy_mask !== 16'h0) begin n_fail++; $display("FAIL mr_busy: got %h, expected 0", busy_mask); end
        n_checks++; if ({a_ready, b_ready} !== 2'b00) begin n_fail++; $display("FAIL mr_ready: got %b, expected 00", {a_ready, b_ready}); end
        sb_a.delete();
        sb_b.delete();
        @(negedge clk);
        n_checks++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL mr_in_reset: got %b, expected 0", rf_we); end
        #2 rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_checks++; if ({rf_we, busy_mask} !== 17'h0) begin n_fail++; $display("FAIL mr_after_%0d: got we=%b busy=%h, expected 0 0000", k, rf_we, busy_mask); end
            if (k == 0) begin
                n_checks++; if ({a_ready, b_ready} !== 2'b11) begin n_fail++; $display("FAIL mr_ready_back: got %b, expected 11", {a_ready, b_ready}); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_pc_priority();
        test_backpressure();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
